// File: rtl/muxnx1_pkg.sv
// Shared defaults and mode encodings for the N:1 round-robin pipelined mux.
package muxnx1_pkg;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_WIDTH = 8;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search over req, starting at a rotating pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [SW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [SW-1:0] r_ptr;

  // Walk from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = int'(r_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant_idx = SW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // N need not be a power of two, so wrap explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en && grant_vld) begin
      r_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/muxnx1_rr_pipe.sv
// N:1 mux with fixed or round-robin selection and a single registered output stage.
module muxnx1_rr_pipe
  import muxnx1_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_sel;

  logic             w_load_en;
  logic [SW-1:0]    w_arb_idx;
  logic             w_arb_vld;
  logic [SW-1:0]    w_grant;
  logic             w_grant_vld;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  assign w_load_en = !r_out_valid || out_ready;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .en        ((mode == MODE_RR) && w_xfer),
    .grant_idx (w_arb_idx),
    .grant_vld (w_arb_vld)
  );

  // Fixed mode grants sel regardless of its valid; out-of-range sel grants nothing.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    if (mode == MODE_RR) begin
      w_grant     = w_arb_idx;
      w_grant_vld = w_arb_vld;
    end else begin
      w_grant     = sel;
      w_grant_vld = int'(sel) < N;
    end
  end

  always_comb begin
    in_ready = '0;
    w_data   = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = w_grant_vld && w_load_en && (int'(w_grant) == k);
      if (int'(w_grant) == k) w_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_xfer = |(in_ready & in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
